alu_writeback: RTL and testbench
================================

# alu_writeback

Writeback stage directly downstream of the ALU: registers the ALU result word(s) and 9-bit output flags, commits them to the 8086 register file (8 general registers, 4 segment registers) and the 16-bit FLAGS register, and serves the two combinational operand read ports that feed the ALU `x`/`y` inputs. Double-width results (MUL/DIV, CWD) are committed over two cycles through a single write port. A valid/ready handshake stalls the upstream issue logic during those cycles.

## Interface
- No parameters.
- `clk`  in  1  sole clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  ALU result present this cycle
- `in_ready`  out  1  stage can accept; transfer occurs when `in_valid & in_ready`
- `alu_out`  in  32  ALU result; `[31:16]` used only when `wr_hi`
- `alu_oflags`  in  9  `{OF,DF,IF,TF,SF,ZF,AF,PF,CF}`
- `dst`  in  4  destination: 0–7 AX,CX,DX,BX,SP,BP,SI,DI; 8–11 ES,CS,SS,DS; 12–15 reserved (write ignored)
- `word_op`  in  1  1 = 16-bit write; 0 = byte write to `dst[1:0]`, high byte when `dst[2]`
- `wr_reg`  in  1  commit `alu_out[15:0]` to `dst`
- `wr_hi`  in  1  additionally commit `alu_out[31:16]` to DX; requires `word_op`
- `wr_flags`  in  1  commit `alu_oflags` into FLAGS
- `rd_a`, `rd_b`  in  4  read addresses; same encoding as `dst`
- `rd_word`  in  1  byte/word select for both read ports
- `x_out`, `y_out`  out  16  operand read data; byte reads zero-extended
- `flags`  out  16  current FLAGS register

## Operation
- Accept: on `in_valid & in_ready`, low-half register write, flag write, and (if `wr_hi`) capture of `alu_out[31:16]` into a holding register, all on the same edge.
- FSM states: IDLE, HI.
  - IDLE → HI on an accepted transfer with `wr_reg & wr_hi`.
  - HI: write the holding register to DX, return to IDLE.
  - `in_ready` = 1 in IDLE and 0 in HI.
- Byte write: modifies only the addressed byte; the other byte is unchanged.
  - Byte writes to `dst` ≥ 8 are ignored.
  - `wr_hi` with `word_op = 0` ignores `wr_hi`.
- Flag merge: FLAGS bits 11,10,9,8,7,6,4,2,0 ← `alu_oflags[8:0]` in order. Fixed bits 15:12 = 1111, bit 1 = 1, bits 5 and 3 = 0; these are never writable.
- Read ports:
  - Word read returns the full register.
  - Byte read returns `{8'h00, byte}`, with the byte selected by `rd_x[2]` from register `rd_x[1:0]`.
  - Reserved addresses read 16'h0000.
- Reset values:
  - All GPRs, ES, SS and DS = 0000; CS = F000; FLAGS = F002.
  - State IDLE; holding register 0000; `in_ready` = 1.
- Reset mid-HI: the pending DX write is discarded and the FSM returns to IDLE. `rst` has priority over every write.

## Timing
- Write latency: 1 cycle; a value written at edge N is visible on registered reads after edge N.
- Double-width write: low half at edge N, DX at edge N+1; `in_ready` is low during cycle N+1.
- Read ports and `in_ready` are combinational from state and inputs; there is no other combinational path from `alu_*` to outputs except the bypass described under Configuration.
- The FSM occupies one extra cycle only for double-width writes; back-to-back single writes sustain 1 transfer per cycle.

## Configuration
- `ALU_WB_BYPASS_EN` defined:
  - Read ports forward the in-flight write data when the read address matches, with byte-merge applied, covering both the accept cycle and the HI-cycle DX write.
  - `flags` likewise forwards the merged flags when `wr_flags` is accepted.
- `ALU_WB_BYPASS_EN` undefined: reads return registered contents only; upstream must insert one bubble on read-after-write.

## Structure
- Shared package holds:
  - register-index constants (AX…DI, ES…DS);
  - FLAGS bit positions;
  - reset constants (`CS` = F000, FLAGS = F002);
  - FLAGS fixed-bit mask.
- One sub-module, `wb_regbank`: 12×16 storage with a byte-enabled write port and two read ports. FSM, flag merge and bypass stay in the top module.

## Test plan
- Reset → `flags` = F002; read CS = F000; read AX = 0000; `in_ready` = 1.
- Word write AX = 1234, then byte write `dst`=4 (AH) = 0xAB, `word_op`=0 → AX reads AB34; byte read AL returns 0034.
- `wr_hi`, `alu_out` = DEAD_BEEF, `dst`=0 → AX = BEEF after cycle 1, `in_ready` = 0 in cycle 2, DX = DEAD after cycle 2; an `in_valid` asserted in cycle 2 is not accepted.
- `wr_flags`, `alu_oflags` = 9'h1FF → `flags` = FFD7; then 9'h000 → `flags` = F002.
- `rst` asserted during the HI cycle of a DEAD_BEEF write → DX = 0000, state IDLE, `in_ready` = 1 next cycle.
- With `ALU_WB_BYPASS_EN`: write CX = 5555 while `rd_a` = 1 → `x_out` = 5555 in the same cycle. Without it: old value 0000 in that cycle, 5555 in the next.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg
// Shared definitions for the ALU writeback stage:
//   - register-file indices (AX..DI, ES..DS) and register count
//   - FLAGS bit positions, reset constants and fixed-bit mask
//   - FSM state type
//   - helpers for flag merging and read-port formatting
package alu_writeback_pkg;

  localparam logic [3:0] IDX_AX = 4'd0;
  localparam logic [3:0] IDX_CX = 4'd1;
  localparam logic [3:0] IDX_DX = 4'd2;
  localparam logic [3:0] IDX_BX = 4'd3;
  localparam logic [3:0] IDX_SP = 4'd4;
  localparam logic [3:0] IDX_BP = 4'd5;
  localparam logic [3:0] IDX_SI = 4'd6;
  localparam logic [3:0] IDX_DI = 4'd7;
  localparam logic [3:0] IDX_ES = 4'd8;
  localparam logic [3:0] IDX_CS = 4'd9;
  localparam logic [3:0] IDX_SS = 4'd10;
  localparam logic [3:0] IDX_DS = 4'd11;
  localparam logic [3:0] NUM_REGS = 4'd12;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_TF = 8;
  localparam int FLAG_IF = 9;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  localparam logic [15:0] CS_RESET         = 16'hF000;
  localparam logic [15:0] FLAGS_RESET      = 16'hF002;
  // Bits 15:12, 5, 3 and 1 are hard-wired; their fixed values are in FLAGS_RESET.
  localparam logic [15:0] FLAGS_FIXED_MASK = 16'hF02A;

  typedef enum logic {IDLE, HI} wb_state_t;

  // Scatter the 9 ALU flag outputs {OF,DF,IF,TF,SF,ZF,AF,PF,CF} into FLAGS.
  function automatic logic [15:0] merge_flags(input logic [8:0] oflags);
    logic [15:0] f;
    f = FLAGS_RESET & FLAGS_FIXED_MASK;
    f[FLAG_OF] = oflags[8];
    f[FLAG_DF] = oflags[7];
    f[FLAG_IF] = oflags[6];
    f[FLAG_TF] = oflags[5];
    f[FLAG_SF] = oflags[4];
    f[FLAG_ZF] = oflags[3];
    f[FLAG_AF] = oflags[2];
    f[FLAG_PF] = oflags[1];
    f[FLAG_CF] = oflags[0];
    return f;
  endfunction

  // Byte addresses 0-7 map onto registers AX..BX, high byte when bit 2 set.
  function automatic logic [3:0] read_index(input logic [3:0] addr, input logic word_sel);
    return word_sel ? addr : {2'b00, addr[1:0]};
  endfunction

  // Word reads pass through (reserved slots already read as zero);
  // byte reads are zero-extended, and byte addresses >= 8 read zero.
  function automatic logic [15:0] format_read(input logic [15:0] word,
                                              input logic [3:0]  addr,
                                              input logic        word_sel);
    if (word_sel) return word;
    if (addr[3]) return 16'h0000;
    return {8'h00, addr[2] ? word[15:8] : word[7:0]};
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// alu_writeback_if
// ALU-result handshake bus into the writeback stage.
//   in_valid/in_ready : transfer on in_valid & in_ready
//   alu_out           : 32-bit result, [31:16] used only for double-width writes
//   alu_oflags        : {OF,DF,IF,TF,SF,ZF,AF,PF,CF}
//   dst, word_op      : destination register and byte/word select
//   wr_reg, wr_hi     : commit low half to dst, high half to DX
//   wr_flags          : commit alu_oflags into FLAGS
// Modports: master (ALU/issue side), slave (writeback stage).
interface alu_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [8:0]  alu_oflags;
  logic [3:0]  dst;
  logic        word_op;
  logic        wr_reg;
  logic        wr_hi;
  logic        wr_flags;

  modport master (
    output in_valid, alu_out, alu_oflags, dst, word_op, wr_reg, wr_hi, wr_flags,
    input  in_ready
  );

  modport slave (
    input  in_valid, alu_out, alu_oflags, dst, word_op, wr_reg, wr_hi, wr_flags,
    output in_ready
  );
endinterface

// File: rtl/alu_writeback_wb_regbank.sv
// wb_regbank
// 12x16 register storage (AX,CX,DX,BX,SP,BP,SI,DI,ES,CS,SS,DS).
//   clk, rst            : clock, synchronous active-high reset (CS -> F000, rest 0)
//   wr_idx/wr_data/wr_be: single write port with per-byte enables;
//                         indices >= 12 are ignored
//   rd_idx_a/rd_idx_b   : two combinational read ports returning the full
//                         word; indices >= 12 read zero
module wb_regbank
  import alu_writeback_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wr_idx,
  input  logic [15:0] wr_data,
  input  logic [1:0]  wr_be,
  input  logic [3:0]  rd_idx_a,
  input  logic [3:0]  rd_idx_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b
);

  logic [15:0] regs [12];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) regs[i] <= 16'h0000;
      regs[IDX_CS] <= CS_RESET;
    end else if (wr_idx < NUM_REGS) begin
      if (wr_be[0]) regs[wr_idx][7:0]  <= wr_data[7:0];
      if (wr_be[1]) regs[wr_idx][15:8] <= wr_data[15:8];
    end
  end

  assign rd_data_a = (rd_idx_a < NUM_REGS) ? regs[rd_idx_a] : 16'h0000;
  assign rd_data_b = (rd_idx_b < NUM_REGS) ? regs[rd_idx_b] : 16'h0000;

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback
// Writeback stage after the 8086 ALU: commits results to the register file
// and FLAGS, and serves the two operand read ports feeding the ALU.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : ALU result handshake (see alu_writeback_if)
//   rd_a, rd_b      : read addresses (same encoding as dst)
//   rd_word         : byte/word select for both read ports
//   x_out, y_out    : operand read data, byte reads zero-extended
//   flags           : current FLAGS
// Optional feature: define ALU_WB_BYPASS_EN to forward in-flight write data
// and merged flags onto the read ports in the same cycle.
module alu_writeback
  import alu_writeback_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_writeback_if.slave   bus,
  input  logic [3:0]       rd_a,
  input  logic [3:0]       rd_b,
  input  logic             rd_word,
  output logic [15:0]      x_out,
  output logic [15:0]      y_out,
  output logic [15:0]      flags
);

  wb_state_t   state, state_next;
  logic [15:0] hold;
  logic [15:0] flags_reg;
  logic        accept;
  logic [3:0]  wr_idx;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [3:0]  idx_a, idx_b;
  logic [15:0] bank_a, bank_b;
  logic [15:0] word_a, word_b;

  // State, DX holding register and FLAGS; reset wins over every write,
  // which also drops a pending DX write when reset lands in HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= 16'h0000;
      flags_reg <= FLAGS_RESET;
    end else begin
      state <= state_next;
      if (accept && bus.wr_reg && bus.word_op && bus.wr_hi) hold <= bus.alu_out[31:16];
      if (accept && bus.wr_flags) flags_reg <= merge_flags(bus.alu_oflags);
    end
  end

  // Next state and the single register write port. A byte write replicates
  // the byte onto both lanes so the byte enable alone picks the lane.
  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    accept       = 1'b0;
    wr_idx       = bus.dst;
    wr_data      = bus.alu_out[15:0];
    wr_be        = 2'b00;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid && bus.wr_reg) begin
          if (bus.word_op) begin
            wr_be = 2'b11;
            if (bus.wr_hi) state_next = HI;
          end else if (!bus.dst[3]) begin
            wr_idx  = {2'b00, bus.dst[1:0]};
            wr_be   = bus.dst[2] ? 2'b10 : 2'b01;
            wr_data = {2{bus.alu_out[7:0]}};
          end
        end
      end
      HI: begin
        wr_idx     = IDX_DX;
        wr_data    = hold;
        wr_be      = 2'b11;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign idx_a = read_index(rd_a, rd_word);
  assign idx_b = read_index(rd_b, rd_word);

  wb_regbank u_regbank (
    .clk       (clk),
    .rst       (rst),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd_idx_a  (idx_a),
    .rd_idx_b  (idx_b),
    .rd_data_a (bank_a),
    .rd_data_b (bank_b)
  );

`ifdef ALU_WB_BYPASS_EN
  // Overlay the in-flight write lanes onto a matching read; writes to
  // reserved slots and writes squashed by reset are never forwarded.
  function automatic logic [15:0] forward(input logic [15:0] base, input logic [3:0] idx,
                                          input logic [3:0] widx, input logic [15:0] wdata,
                                          input logic [1:0] be, input logic en);
    logic [15:0] r;
    r = base;
    if (en && idx == widx && widx < NUM_REGS) begin
      if (be[0]) r[7:0]  = wdata[7:0];
      if (be[1]) r[15:8] = wdata[15:8];
    end
    return r;
  endfunction

  assign word_a = forward(bank_a, idx_a, wr_idx, wr_data, wr_be, !rst);
  assign word_b = forward(bank_b, idx_b, wr_idx, wr_data, wr_be, !rst);
  assign flags  = (accept && bus.wr_flags && !rst) ? merge_flags(bus.alu_oflags) : flags_reg;
`else
  assign word_a = bank_a;
  assign word_b = bank_b;
  assign flags  = flags_reg;
`endif

  assign x_out = format_read(word_a, rd_a, rd_word);
  assign y_out = format_read(word_b, rd_b, rd_word);

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback
// Self-checking bench for alu_writeback: directed scenarios followed by
// randomized traffic, all compared against an array-based register-file
// model held in the bench. Honours ALU_WB_BYPASS_EN for same-cycle reads.
module tb_alu_writeback;

`ifdef ALU_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rd_a, rd_b;
  logic        rd_word;
  logic [15:0] x_out, y_out, flags;

  alu_writeback_if bus ();

  alu_writeback dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .rd_word (rd_word),
    .x_out   (x_out),
    .y_out   (y_out),
    .flags   (flags)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: m_* is the architectural state now, n_* after the next edge.
  logic [15:0] m_regs [12];
  logic [15:0] n_regs [12];
  logic [15:0] m_flags, n_flags, m_hold, n_hold;
  bit          m_hi, n_hi;

  // Values seen at the last sample point, for directed constant checks.
  logic [15:0] obs_x, obs_y, obs_flags;
  logic        obs_ready;

  // Counts one comparison and reports it if it differs.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Position of ALU flag output i inside FLAGS: CF,PF,AF,ZF,SF,TF,IF,DF,OF.
  function automatic int flagPos(input int i);
    case (i)
      0: return 0;
      1: return 2;
      2: return 4;
      3: return 6;
      4: return 7;
      5: return 8;
      6: return 9;
      7: return 10;
      default: return 11;
    endcase
  endfunction

  // Reads the model register file as the ALU would see it.
  function automatic logic [15:0] readView(input bit useNext, input logic [3:0] addr, input bit word);
    logic [15:0] r;
    int idx;
    if (word) begin
      if (addr >= 12) return 16'h0000;
      idx = int'(addr);
      return useNext ? n_regs[idx] : m_regs[idx];
    end
    if (addr >= 8) return 16'h0000;
    idx = int'(addr) % 4;
    r = useNext ? n_regs[idx] : m_regs[idx];
    return (addr >= 4) ? (r >> 8) : (r & 16'h00FF);
  endfunction

  // Computes the architectural state after the coming edge from the inputs.
  function automatic void computeNext();
    int r;
    logic [15:0] lo;
    for (int i = 0; i < 12; i++) n_regs[i] = m_regs[i];
    n_flags = m_flags;
    n_hold  = m_hold;
    n_hi    = 1'b0;
    if (rst) begin
      for (int i = 0; i < 12; i++) n_regs[i] = 16'h0000;
      n_regs[9] = 16'hF000;
      n_flags   = 16'hF002;
      n_hold    = 16'h0000;
    end else if (m_hi) begin
      n_regs[2] = m_hold;
    end else if (bus.in_valid) begin
      lo = bus.alu_out[15:0];
      if (bus.wr_reg) begin
        if (bus.word_op) begin
          if (bus.dst < 12) n_regs[int'(bus.dst)] = lo;
          if (bus.wr_hi) begin
            n_hold = bus.alu_out[31:16];
            n_hi   = 1'b1;
          end
        end else if (bus.dst < 8) begin
          r = int'(bus.dst) % 4;
          if (bus.dst >= 4) n_regs[r] = (m_regs[r] & 16'h00FF) | (16'(lo[7:0]) << 8);
          else              n_regs[r] = (m_regs[r] & 16'hFF00) | 16'(lo[7:0]);
        end
      end
      if (bus.wr_flags) begin
        n_flags = 16'hF002;
        for (int i = 0; i < 9; i++)
          if (bus.alu_oflags[i]) n_flags = n_flags | (16'h0001 << flagPos(i));
      end
    end
  endfunction

  // Drives one cycle of inputs at the falling edge, checks the outputs
  // against the model (skipped while reset is held), then advances the
  // model across the rising edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] data,
                               input logic [8:0] oflags, input logic [3:0] d,
                               input bit wo, input bit wreg, input bit whi, input bit wfl,
                               input logic [3:0] ra, input logic [3:0] rb, input bit rw);
    @(negedge clk);
    rst            = r;
    bus.in_valid   = v;
    bus.alu_out    = data;
    bus.alu_oflags = oflags;
    bus.dst        = d;
    bus.word_op    = wo;
    bus.wr_reg     = wreg;
    bus.wr_hi      = whi;
    bus.wr_flags   = wfl;
    rd_a           = ra;
    rd_b           = rb;
    rd_word        = rw;
    computeNext();
    #1;
    obs_x     = x_out;
    obs_y     = y_out;
    obs_flags = flags;
    obs_ready = bus.in_ready;
    if (!r) begin
      checkOutput("in_ready", {15'h0, bus.in_ready}, {15'h0, !m_hi});
      checkOutput("x_out", x_out, readView(BYPASS, ra, rw));
      checkOutput("y_out", y_out, readView(BYPASS, rb, rw));
      checkOutput("flags", flags, BYPASS ? n_flags : m_flags);
    end
    @(posedge clk);
    for (int i = 0; i < 12; i++) m_regs[i] = n_regs[i];
    m_flags = n_flags;
    m_hold  = n_hold;
    m_hi    = n_hi;
  endtask

  // A cycle with no transfer, just reading.
  task automatic idleRead(input logic [3:0] ra, input logic [3:0] rb, input bit rw);
    applyStimulus(0, 0, 32'h0, 9'h0, 4'h0, 0, 0, 0, 0, ra, rb, rw);
  endtask

  // Directed scenarios first, then randomized traffic, then the summary.
  initial begin
    bit r, v, wo, wreg, whi, wfl, rw;
    logic [3:0] d, ra, rb;

    for (int i = 0; i < 12; i++) m_regs[i] = 16'h0000;
    m_flags = 16'h0000;
    m_hold  = 16'h0000;
    m_hi    = 1'b0;

    applyStimulus(1, 0, 32'h0, 9'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
    applyStimulus(1, 0, 32'h0, 9'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 1);

    // Reset values.
    idleRead(4'd9, 4'd0, 1);
    checkOutput("reset_cs", obs_x, 16'hF000);
    checkOutput("reset_ax", obs_y, 16'h0000);
    checkOutput("reset_flags", obs_flags, 16'hF002);
    checkOutput("reset_ready", {15'h0, obs_ready}, 16'h0001);

    // Word write then high-byte write into AX.
    applyStimulus(0, 1, 32'h0000_1234, 9'h0, 4'd0, 1, 1, 0, 0, 4'd0, 4'd0, 1);
    applyStimulus(0, 1, 32'h0000_00AB, 9'h0, 4'd4, 0, 1, 0, 0, 4'd0, 4'd0, 1);
    idleRead(4'd0, 4'd0, 1);
    checkOutput("ax_after_ah", obs_x, 16'hAB34);
    idleRead(4'd0, 4'd4, 0);
    checkOutput("al_byte", obs_x, 16'h0034);
    checkOutput("ah_byte", obs_y, 16'h00AB);

    // Double-width write; the transfer offered during HI is refused.
    applyStimulus(0, 1, 32'hDEAD_BEEF, 9'h0, 4'd0, 1, 1, 1, 0, 4'd0, 4'd2, 1);
    applyStimulus(0, 1, 32'h0000_7777, 9'h0, 4'd1, 1, 1, 0, 0, 4'd0, 4'd1, 1);
    checkOutput("hi_ready", {15'h0, obs_ready}, 16'h0000);
    checkOutput("hi_ax", obs_x, 16'hBEEF);
    idleRead(4'd2, 4'd1, 1);
    checkOutput("hi_dx", obs_x, 16'hDEAD);
    checkOutput("hi_cx_refused", obs_y, 16'h0000);

    // Flag merge with all ones and all zeros.
    applyStimulus(0, 1, 32'h0, 9'h1FF, 4'd0, 1, 0, 0, 1, 4'd0, 4'd0, 1);
    idleRead(4'd0, 4'd0, 1);
    checkOutput("flags_ones", obs_flags, 16'hFFD7);
    applyStimulus(0, 1, 32'h0, 9'h000, 4'd0, 1, 0, 0, 1, 4'd0, 4'd0, 1);
    idleRead(4'd0, 4'd0, 1);
    checkOutput("flags_zeros", obs_flags, 16'hF002);

    // Reset during the HI cycle discards the DX write.
    applyStimulus(0, 1, 32'hDEAD_BEEF, 9'h0, 4'd0, 1, 1, 1, 0, 4'd0, 4'd0, 1);
    applyStimulus(1, 0, 32'h0, 9'h0, 4'h0, 0, 0, 0, 0, 4'd2, 4'd0, 1);
    idleRead(4'd2, 4'd0, 1);
    checkOutput("rst_hi_dx", obs_x, 16'h0000);
    checkOutput("rst_hi_ready", {15'h0, obs_ready}, 16'h0001);

    // Read-after-write on CX, same cycle and next cycle.
    applyStimulus(0, 1, 32'h0000_5555, 9'h0, 4'd1, 1, 1, 0, 0, 4'd1, 4'd0, 1);
    checkOutput("raw_same_cycle", obs_x, BYPASS ? 16'h5555 : 16'h0000);
    idleRead(4'd1, 4'd0, 1);
    checkOutput("raw_next_cycle", obs_x, 16'h5555);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      r    = ($urandom_range(0, 49) == 0);
      v    = ($urandom_range(0, 3) != 0);
      d    = 4'($urandom_range(0, 15));
      wo   = 1'($urandom);
      wreg = ($urandom_range(0, 3) != 0);
      whi  = ($urandom_range(0, 3) == 0);
      wfl  = 1'($urandom);
      rw   = 1'($urandom);
      ra   = rw ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      rb   = rw ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      applyStimulus(r, v, 32'($urandom), 9'($urandom), d, wo, wreg, whi, wfl, ra, rb, rw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
